// File: rtl/data_bus_adapter.sv
// data_bus_adapter: turns one LSU access into one req/gnt/rvalid data-bus
// transaction. Byte enables and store data are shifted up to the addressed
// lane. Load data is shifted back down to lane 0. Misaligned accesses are
// rejected without touching the bus.
// Optional feature macro: DATA_BUS_TIMEOUT_EN enables a watchdog. If the
// bus does not complete within TIMEOUT_CYCLES, the watchdog ends the access
// with an error.
module data_bus_adapter #(
    parameter int DATA_WIDTH     = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  lsu_req_i,
    input  logic                  lsu_we_i,
    input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
    input  logic [3:0]            lsu_be_i,
    input  logic [DATA_WIDTH-1:0] lsu_wdata_i,
    output logic                  lsu_stall_o,
    output logic                  lsu_rvalid_o,
    output logic [DATA_WIDTH-1:0] lsu_rdata_o,
    output logic                  lsu_err_o,
    output logic                  bus_req_o,
    input  logic                  bus_gnt_i,
    output logic [ADDR_WIDTH-1:0] bus_addr_o,
    output logic                  bus_we_o,
    output logic [3:0]            bus_be_o,
    output logic [DATA_WIDTH-1:0] bus_wdata_o,
    input  logic                  bus_rvalid_i,
    input  logic [DATA_WIDTH-1:0] bus_rdata_i
);

    typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

    state_t     state, state_nxt;
    logic [1:0] off, off_q;
    logic       accepting, misaligned, accept;
    logic       tmo_hit, tmo_err;

    assign off       = lsu_addr_i[1:0];
    assign accepting = (state == IDLE) || (state == DONE);
    assign accept    = accepting && lsu_req_i && !misaligned;

    // Legal patterns: a byte anywhere, a halfword on an even offset,
    // a word on offset 0
    always_comb begin
        misaligned = 1'b1;
        case (lsu_be_i)
            4'b0001: misaligned = 1'b0;
            4'b0011: misaligned = off[0];
            4'b1111: misaligned = (off != 2'b00);
            default: misaligned = 1'b1;
        endcase
    end

`ifdef DATA_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_q;

    // The timeout fires on the cycle that would bring the count to TIMEOUT_CYCLES
    assign tmo_hit = ((state == REQ) || (state == RESP)) && (tmo_cnt == TMO_LAST);
    assign tmo_err = (state == DONE) && tmo_q;

    // The watchdog counts the cycles spent waiting on the bus. tmo_q marks
    // the DONE cycle that the timeout produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            tmo_q   <= 1'b0;
        end else begin
            if (accept)
                tmo_cnt <= '0;
            else if ((state == REQ) || (state == RESP))
                tmo_cnt <= tmo_cnt + 1'b1;
            tmo_q <= tmo_hit;
        end
    end
`else
    logic unused_tmo_cfg;

    assign tmo_hit        = 1'b0;
    assign tmo_err        = 1'b0;
    assign unused_tmo_cfg = ^TIMEOUT_CYCLES;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic. The bus grant is only looked at in REQ and the
    // response only in RESP, so a stray handshake elsewhere has no effect.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (accept) state_nxt = REQ;
            REQ: begin
                if (tmo_hit)        state_nxt = DONE;
                else if (bus_gnt_i) state_nxt = RESP;
            end
            RESP: begin
                if (tmo_hit)           state_nxt = DONE;
                else if (bus_rvalid_i) state_nxt = DONE;
            end
            DONE:    state_nxt = accept ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    assign bus_req_o    = (state == REQ);
    assign lsu_rvalid_o = (state == DONE);
    assign lsu_stall_o  = accept || (state == REQ) || (state == RESP);
    assign lsu_err_o    = (accepting && lsu_req_i && misaligned) || tmo_err;

    // Bus-side registers load on acceptance and stay stable for the whole
    // transaction. Load data is captured, shifted down to lane 0, when the
    // response arrives.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus_addr_o  <= '0;
            bus_we_o    <= 1'b0;
            bus_be_o    <= '0;
            bus_wdata_o <= '0;
            off_q       <= '0;
            lsu_rdata_o <= '0;
        end else begin
            if (accept) begin
                bus_addr_o  <= {lsu_addr_i[ADDR_WIDTH-1:2], 2'b00};
                bus_we_o    <= lsu_we_i;
                bus_be_o    <= lsu_be_i << off;
                bus_wdata_o <= lsu_wdata_i << {off, 3'b000};
                off_q       <= off;
            end
            if (tmo_hit)
                lsu_rdata_o <= '0;
            else if ((state == RESP) && bus_rvalid_i)
                lsu_rdata_o <= bus_we_o ? '0 : (bus_rdata_i >> {off_q, 3'b000});
        end
    end

endmodule

// File: tb/tb_data_bus_adapter.sv
// Bench for data_bus_adapter. The bench pushes expected completions to a
// scoreboard queue and pops them when lsu_rvalid_o is seen.
module tb_data_bus_adapter;

    localparam int TMO = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        lsu_req_i, lsu_we_i;
    logic [31:0] lsu_addr_i, lsu_wdata_i;
    logic [3:0]  lsu_be_i;
    logic        lsu_stall_o, lsu_rvalid_o, lsu_err_o;
    logic [31:0] lsu_rdata_o;
    logic        bus_req_o, bus_gnt_i, bus_we_o, bus_rvalid_i;
    logic [31:0] bus_addr_o, bus_wdata_o, bus_rdata_i;
    logic [3:0]  bus_be_o;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    data_bus_adapter #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_be_i(lsu_be_i), .lsu_wdata_i(lsu_wdata_i),
        .lsu_stall_o(lsu_stall_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o), .lsu_err_o(lsu_err_o),
        .bus_req_o(bus_req_o), .bus_gnt_i(bus_gnt_i), .bus_addr_o(bus_addr_o),
        .bus_we_o(bus_we_o), .bus_be_o(bus_be_o), .bus_wdata_o(bus_wdata_o),
        .bus_rvalid_i(bus_rvalid_i), .bus_rdata_i(bus_rdata_i)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Completion monitor: every lsu_rvalid_o pulse must match the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (lsu_rvalid_o) begin
            if (sb.size() == 0) begin
                chk("spurious_rvalid", 32'(lsu_rvalid_o), 32'd0);
            end else begin
                e = sb.pop_front();
                chk("lsu_rdata", lsu_rdata_o, e.rdata);
                chk("lsu_err_done", 32'(lsu_err_o), 32'(e.err));
            end
        end
    end

    // Called mid-cycle (after a posedge). On return the DUT is in its DONE
    // cycle, and the caller may issue the next request immediately.
    task automatic do_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input int g, input int r,
                             input logic [31:0] x_addr, input logic [3:0] x_be,
                             input logic [31:0] x_wdata, input logic [31:0] x_rdata);
        lsu_req_i   = 1'b1;
        lsu_we_i    = we;
        lsu_addr_i  = addr;
        lsu_be_i    = be;
        lsu_wdata_i = wdata;
        #1;
        chk("stall_req_cycle", 32'(lsu_stall_o), 32'd1);
        chk("err_legal", 32'(lsu_err_o), 32'd0);
        sb.push_back('{rdata: x_rdata, err: 1'b0});
        step();
        lsu_req_i = 1'b0;
        #1;
        chk("bus_req_req", 32'(bus_req_o), 32'd1);
        chk("bus_addr", bus_addr_o, x_addr);
        chk("bus_be", 32'(bus_be_o), 32'(x_be));
        chk("bus_wdata", bus_wdata_o, x_wdata);
        chk("bus_we", 32'(bus_we_o), 32'(we));
        chk("stall_req", 32'(lsu_stall_o), 32'd1);
        for (int i = 0; i < g; i++) begin
            step();
            #1;
            chk("bus_req_hold", 32'(bus_req_o), 32'd1);
            chk("bus_addr_hold", bus_addr_o, x_addr);
            chk("bus_be_hold", 32'(bus_be_o), 32'(x_be));
            chk("bus_wdata_hold", bus_wdata_o, x_wdata);
            chk("stall_wait_gnt", 32'(lsu_stall_o), 32'd1);
        end
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        #1;
        chk("bus_req_resp", 32'(bus_req_o), 32'd0);
        chk("stall_resp", 32'(lsu_stall_o), 32'd1);
        for (int i = 0; i < r; i++) begin
            step();
            #1;
            chk("stall_wait_rv", 32'(lsu_stall_o), 32'd1);
            chk("rvalid_early", 32'(lsu_rvalid_o), 32'd0);
        end
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = rdata;
        step();
        bus_rvalid_i = 1'b0;
        bus_rdata_i  = 32'h5A5A_5A5A;
        #1;
        chk("rvalid_done", 32'(lsu_rvalid_o), 32'd1);
        chk("stall_done", 32'(lsu_stall_o), 32'd0);
    endtask

    task automatic bad_access(input logic [31:0] addr, input logic [3:0] be);
        lsu_req_i  = 1'b1;
        lsu_we_i   = 1'b0;
        lsu_addr_i = addr;
        lsu_be_i   = be;
        #1;
        chk("err_misaligned", 32'(lsu_err_o), 32'd1);
        chk("stall_misaligned", 32'(lsu_stall_o), 32'd0);
        chk("bus_req_misaligned", 32'(bus_req_o), 32'd0);
        step();
        lsu_req_i = 1'b0;
        #1;
        chk("bus_req_after_bad", 32'(bus_req_o), 32'd0);
        chk("rvalid_after_bad", 32'(lsu_rvalid_o), 32'd0);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, want bench completion");
        $fatal(1, "bench watchdog expired");
    end

    initial begin
        rst = 1'b1; lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_addr_i = '0; lsu_be_i = '0;
        lsu_wdata_i = '0; bus_gnt_i = 1'b0; bus_rvalid_i = 1'b0; bus_rdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("rst_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_bus_addr", bus_addr_o, 32'd0);
        chk("rst_bus_we", 32'(bus_we_o), 32'd0);
        chk("rst_bus_be", 32'(bus_be_o), 32'd0);
        chk("rst_bus_wdata", bus_wdata_o, 32'd0);
        chk("rst_rvalid", 32'(lsu_rvalid_o), 32'd0);
        chk("rst_rdata", lsu_rdata_o, 32'd0);
        chk("rst_stall", 32'(lsu_stall_o), 32'd0);
        step();

        // Word load, minimum latency
        do_access(1'b0, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 0, 0,
                  32'h100, 4'b1111, 32'h0, 32'hDEADBEEF);
        step();
        // Byte store to lane 3; the bus returns junk that must not reach the LSU
        do_access(1'b1, 32'h203, 4'b0001, 32'h0000_00A5, 32'hFFFF_FFFF, 0, 0,
                  32'h200, 4'b1000, 32'hA500_0000, 32'h0);
        step();
        // Halfword load from upper half, then a back-to-back byte load from lane 1
        do_access(1'b0, 32'h302, 4'b0011, 32'h0, 32'h1234ABCD, 0, 0,
                  32'h300, 4'b1100, 32'h0, 32'h0000_1234);
        do_access(1'b0, 32'h001, 4'b0001, 32'h0, 32'h0000_AB00, 1, 0,
                  32'h000, 4'b0010, 32'h0, 32'h0000_00AB);
        step();
        // Byte load from lane 2
        do_access(1'b0, 32'h0A2, 4'b0001, 32'h0, 32'h0077_0000, 0, 2,
                  32'h0A0, 4'b0100, 32'h0, 32'h0000_0077);
        step();
        // Grant delayed 3 cycles, response 2 cycles after grant
        do_access(1'b1, 32'h102, 4'b0011, 32'h0000_BEEF, 32'h0, 3, 1,
                  32'h100, 4'b1100, 32'hBEEF_0000, 32'h0);
        step();
        do_access(1'b1, 32'h7FC, 4'b1111, 32'h1234_5678, 32'h0, 1, 2,
                  32'h7FC, 4'b1111, 32'h1234_5678, 32'h0);
        step();

        // Rejected accesses
        bad_access(32'h401, 4'b1111);
        bad_access(32'h402, 4'b1111);
        bad_access(32'h301, 4'b0011);
        bad_access(32'h000, 4'b0101);

        // Reset during RESP, followed by a stray response
        lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h500; lsu_be_i = 4'b1111;
        step();
        lsu_req_i = 1'b0;
        repeat (3) step();
        bus_gnt_i = 1'b1;
        step();
        bus_gnt_i = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        #1;
        chk("rst_mid_bus_req", 32'(bus_req_o), 32'd0);
        chk("rst_mid_stall", 32'(lsu_stall_o), 32'd0);
        chk("rst_mid_addr", bus_addr_o, 32'd0);
        bus_rvalid_i = 1'b1;
        bus_rdata_i  = 32'hCAFE_F00D;
        step();
        bus_rvalid_i = 1'b0;
        #1;
        chk("stray_rvalid", 32'(lsu_rvalid_o), 32'd0);
        step();
        #1;
        chk("stray_rvalid2", 32'(lsu_rvalid_o), 32'd0);
        chk("stray_rdata", lsu_rdata_o, 32'd0);
        step();

`ifdef DATA_BUS_TIMEOUT_EN
        begin
            int  waited;
            bit  seen;
            seen = 1'b0;
            waited = 0;
            lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h600; lsu_be_i = 4'b1111;
            sb.push_back('{rdata: 32'h0, err: 1'b1});
            step();
            lsu_req_i = 1'b0;
            for (int i = 0; i < 40 && !seen; i++) begin
                step();
                #1;
                waited++;
                if (lsu_rvalid_o) seen = 1'b1;
            end
            chk("tmo_seen", 32'(seen), 32'd1);
            chk("tmo_err", 32'(lsu_err_o), 32'd1);
            chk("tmo_bus_req", 32'(bus_req_o), 32'd0);
            chk("tmo_not_early", 32'(waited >= TMO - 1), 32'd1);
            step();
            bus_rvalid_i = 1'b1;
            bus_rdata_i  = 32'h1111_2222;
            step();
            bus_rvalid_i = 1'b0;
            #1;
            chk("tmo_late_rvalid", 32'(lsu_rvalid_o), 32'd0);
            step();
        end
`endif

        repeat (2) step();
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/data_bus_adapter.md
Name: data_bus_adapter

Overview:
- Sits directly downstream of the load/store unit. Converts a single LSU access into one transaction on the core's data bus, which uses a req/gnt/rvalid handshake (OBI-style).
- Lane alignment:
  - Byte enables and write data from the LSU arrive low-lane justified; the block shifts them to the lane given by the address.
  - Read data returns from the bus and is shifted down to lane 0, ready for the LSU sign/zero extension.
- Holds the core stalled until the bus response arrives. Rejects misaligned accesses without touching the bus.

Parameters:
- DATA_WIDTH, 32, data bus width; fixed at 32, 4 byte lanes.
- ADDR_WIDTH, 32, address width.
- TIMEOUT_CYCLES, 255, watchdog limit in cycles; used only when DATA_BUS_TIMEOUT_EN is defined.

Ports:
- clk  in  1  core clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- lsu_req_i  in  1  access request, held until accepted.
- lsu_we_i  in  1  0 = load, 1 = store.
- lsu_addr_i  in  ADDR_WIDTH  byte address.
- lsu_be_i  in  4  low-justified byte enable: 0001, 0011 or 1111.
- lsu_wdata_i  in  DATA_WIDTH  low-justified store data.
- lsu_stall_o  out  1  core must hold the current access.
- lsu_rvalid_o  out  1  one-cycle completion pulse.
- lsu_rdata_o  out  DATA_WIDTH  load data, shifted down to lane 0.
- lsu_err_o  out  1  misaligned or illegal access (and timeout, see Optional Feature).
- bus_req_o  out  1  bus request.
- bus_gnt_i  in  1  bus grant.
- bus_addr_o  out  ADDR_WIDTH  word-aligned address, bits [1:0] = 00.
- bus_we_o  out  1  write enable.
- bus_be_o  out  4  lane-shifted byte enable.
- bus_wdata_o  out  DATA_WIDTH  lane-shifted write data.
- bus_rvalid_i  in  1  response valid.
- bus_rdata_i  in  DATA_WIDTH  response data.

Behaviour:
- Reset values: state IDLE. All outputs 0: bus_req_o, bus_addr_o, bus_we_o, bus_be_o, bus_wdata_o, lsu_rvalid_o, lsu_rdata_o.
- Reset in any state, including mid-transaction:
  - bus_req_o drops the next cycle.
  - Any outstanding response is discarded.
- States are IDLE, REQ, RESP, DONE. A new request is accepted in IDLE or DONE (the "accepting" states).
- Offset: off = lsu_addr_i[1:0].
- Misaligned/illegal access is any of:
  - be = 0011 with off odd;
  - be = 1111 with off != 00;
  - any other be pattern.
- lsu_err_o (combinational) = accepting && lsu_req_i && misaligned. In that case there is no bus activity, lsu_stall_o = 0 and the state does not change.
- Accepted access, edge into REQ:
  - Latch bus_addr_o = {addr[ADDR_WIDTH-1:2], 2'b00}.
  - Latch bus_we_o = lsu_we_i.
  - Latch bus_be_o = lsu_be_i << off.
  - Latch bus_wdata_o = lsu_wdata_i << 8*off.
  - Set bus_req_o = 1.
- REQ:
  - bus_req_o and all bus_* outputs are held stable until bus_gnt_i = 1.
  - On grant: bus_req_o = 0 next cycle, go to RESP.
  - bus_gnt_i is ignored in every other state.
- RESP:
  - Wait for bus_rvalid_i; there is no lower bound on wait cycles.
  - On rvalid: lsu_rdata_o <= bus_rdata_i >> 8*off_latched, go to DONE.
  - For stores, lsu_rdata_o <= 0.
- bus_rvalid_i is ignored outside RESP; a stray rvalid has no effect.
- DONE:
  - lsu_rvalid_o = 1 for exactly this cycle.
  - With no new request, go to IDLE.
  - A new request can be accepted in DONE (back-to-back accesses).
  - lsu_rdata_o holds its value until the next completion.
- lsu_stall_o = (accepting && lsu_req_i && !misaligned) || state == REQ || state == RESP.
- Minimum latency, gnt in the first REQ cycle and rvalid in the first RESP cycle: request cycle T, REQ at T+1, RESP at T+2, DONE (lsu_rvalid_o) at T+3.
- At most one outstanding transaction.

Optional Feature:
- Macro: DATA_BUS_TIMEOUT_EN.
- Defined:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on acceptance and increments every cycle in REQ or RESP.
  - When it reaches TIMEOUT_CYCLES: bus_req_o drops, go to DONE.
  - In that DONE cycle, lsu_rvalid_o = 1, lsu_err_o = 1 and lsu_rdata_o = 0.
  - A late rvalid is ignored.
- Not defined: no counter exists, and the block waits indefinitely in REQ or RESP.

Test Plan:
- Word load at 0x100, be = 1111; gnt in the first cycle, rvalid 1 cycle later with rdata 0xDEADBEEF -> bus_addr_o = 0x100, bus_be_o = 1111, lsu_rvalid_o at T+3, lsu_rdata_o = 0xDEADBEEF, lsu_stall_o high at T, T+1 and T+2.
- Byte store at 0x203, be = 0001, wdata 0x000000A5 -> bus_addr_o = 0x200, bus_be_o = 1000, bus_wdata_o = 0xA5000000, bus_we_o = 1.
- Halfword load at 0x302, be = 0011, bus_rdata_i = 0x1234ABCD -> lsu_rdata_o = 0x00001234.
- Word load at 0x401 -> lsu_err_o = 1 in the same cycle, lsu_stall_o = 0, bus_req_o stays 0.
- Grant delayed 3 cycles, then rvalid after 2 more, with rst asserted for one cycle in RESP on a second run:
  - Without reset: bus outputs stable while waiting for grant, completes normally.
  - With reset: the state returns to IDLE and a later stray rvalid produces no lsu_rvalid_o.
- With DATA_BUS_TIMEOUT_EN and TIMEOUT_CYCLES = 8, gnt never asserted -> 8 cycles after acceptance, lsu_rvalid_o = 1, lsu_err_o = 1, bus_req_o = 0.
